// File: rtl/mult_pipe_pkg.sv
// Shared types for the multiplier slice: core config, FU opcodes and the
// mult-op classifier used by both issue and the multiplier.
package mult_pipe_pkg;

  typedef struct packed {
    int unsigned XLEN;
    bit          IS_XLEN64;
    int unsigned TRANS_ID_BITS;
    int unsigned NUM_THREADS;
    int unsigned NUM_THREADS_LOG;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    XLEN:            64,
    IS_XLEN64:       1'b1,
    TRANS_ID_BITS:   3,
    NUM_THREADS:     2,
    NUM_THREADS_LOG: 1
  };

  typedef enum logic [3:0] {
    ADD,
    SUB,
    MUL,
    MULH,
    MULHU,
    MULHSU,
    MULW,
    DIV
  } fu_op;

  function automatic logic is_mult_op(input fu_op op);
    return (op == MUL) || (op == MULH) || (op == MULHU) || (op == MULHSU) || (op == MULW);
  endfunction

  function automatic logic [63:0] sext32to64(input logic [31:0] val);
    return {{32{val[31]}}, val};
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One pipeline register: loads payload when enabled, otherwise holds,
// and drops its valid bit when the held op belongs to a flushed thread.
module mult_pipe_stage #(
  parameter type      payload_t = logic,
  parameter payload_t ResetVal  = '0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     en_i,
  input  logic     kill_i,
  input  logic     valid_i,
  input  payload_t data_i,
  output logic     valid_o,
  output payload_t data_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= ResetVal;
    end else if (en_i) begin
      valid_o <= valid_i;
      data_o  <= data_i;
    end else if (kill_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Multi-thread integer multiplier: product formed in stage 0, carried through
// NumStages retimable registers, with per-thread flush and output backpressure.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg   = cva6_cfg_empty,
  parameter int unsigned NumStages = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [CVA6Cfg.NUM_THREADS-1:0]       flush_i,
  input  logic                                 mult_valid_i,
  output logic                                 mult_ready_o,
  input  fu_op                                 operation_i,
  input  logic [CVA6Cfg.TRANS_ID_BITS-1:0]     trans_id_i,
  input  logic [CVA6Cfg.NUM_THREADS_LOG-1:0]   thread_id_i,
  input  logic [CVA6Cfg.XLEN-1:0]              operand_a_i,
  input  logic [CVA6Cfg.XLEN-1:0]              operand_b_i,
  output logic                                 mult_valid_o,
  input  logic                                 mult_ready_i,
  output logic [CVA6Cfg.XLEN-1:0]              result_o,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0]     mult_trans_id_o,
  output logic [CVA6Cfg.NUM_THREADS_LOG-1:0]   mult_thread_id_o
);

  localparam int unsigned XLEN = CVA6Cfg.XLEN;
  localparam int unsigned TidW = CVA6Cfg.TRANS_ID_BITS;
  localparam int unsigned ThW  = CVA6Cfg.NUM_THREADS_LOG;

  typedef struct packed {
    fu_op                  op;
    logic [TidW-1:0]       trans_id;
    logic [ThW-1:0]        thread_id;
    logic [2*XLEN-1:0]     product;
  } payload_t;

  localparam payload_t PayloadRst = '{op: MUL, default: '0};

  logic [NumStages-1:0] v, en, kill, d_v;
  payload_t             d_pl [NumStages];
  payload_t             q_pl [NumStages];
  payload_t             in_pl;
  payload_t             last;
  logic                 accept;
  logic                 sign_a, sign_b;
  logic [2*XLEN-1:0]    a_wide, b_wide;
  logic [XLEN-1:0]      mulw_res;

  // Extending to 2*XLEN and keeping the low half of an unsigned multiply
  // yields the same bits as the (XLEN+1)x(XLEN+1) signed product.
  always_comb begin
    sign_a         = ((operation_i == MULH) || (operation_i == MULHSU)) && operand_a_i[XLEN-1];
    sign_b         = (operation_i == MULH) && operand_b_i[XLEN-1];
    a_wide         = {{XLEN{sign_a}}, operand_a_i};
    b_wide         = {{XLEN{sign_b}}, operand_b_i};
    in_pl          = PayloadRst;
    in_pl.op       = operation_i;
    in_pl.trans_id = trans_id_i;
    in_pl.thread_id = thread_id_i;
    in_pl.product  = a_wide * b_wide;
  end

  // A stage may advance if it is empty or the stage ahead advances.
  always_comb begin
    en = '0;
    en[NumStages-1] = ~v[NumStages-1] | mult_ready_i;
    for (int unsigned i = 1; i < NumStages; i++) begin
      en[NumStages-1-i] = ~v[NumStages-1-i] | en[NumStages-i];
    end
  end

  assign mult_ready_o = en[0];
  assign accept = mult_valid_i & mult_ready_o & is_mult_op(operation_i) & ~flush_i[thread_id_i];

  for (genvar k = 0; k < NumStages; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign d_v[k]  = accept;
      assign d_pl[k] = in_pl;
    end else begin : g_body
      // An op moving forward while its thread is flushed dies in transit.
      assign d_v[k]  = v[k-1] & ~flush_i[q_pl[k-1].thread_id];
      assign d_pl[k] = q_pl[k-1];
    end

    assign kill[k] = v[k] & flush_i[q_pl[k].thread_id];

    mult_pipe_stage #(
      .payload_t (payload_t),
      .ResetVal  (PayloadRst)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (en[k]),
      .kill_i  (kill[k]),
      .valid_i (d_v[k]),
      .data_i  (d_pl[k]),
      .valid_o (v[k]),
      .data_o  (q_pl[k])
    );
  end

  assign last             = q_pl[NumStages-1];
  assign mult_valid_o     = v[NumStages-1] & ~flush_i[last.thread_id];
  assign mult_trans_id_o  = last.trans_id;
  assign mult_thread_id_o = last.thread_id;

  if (CVA6Cfg.IS_XLEN64) begin : g_mulw64
    assign mulw_res = sext32to64(last.product[31:0]);
  end else begin : g_mulw32
    assign mulw_res = last.product[XLEN-1:0];
  end

  always_comb begin
    result_o = last.product[XLEN-1:0];
    case (last.op)
      MULH, MULHU, MULHSU: result_o = last.product[2*XLEN-1:XLEN];
      MULW:                result_o = mulw_res;
      default:             ;
    endcase
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Randomized and directed bench for mult_pipe against an arithmetic reference
// model with an in-order scoreboard of in-flight operations.
module tb_mult_pipe;
  import mult_pipe_pkg::*;

  localparam int unsigned N = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  flush_i;
  logic        mult_valid_i;
  logic        mult_ready_o;
  fu_op        operation_i;
  logic [2:0]  trans_id_i;
  logic [0:0]  thread_id_i;
  logic [63:0] operand_a_i;
  logic [63:0] operand_b_i;
  logic        mult_valid_o;
  logic        mult_ready_i;
  logic [63:0] result_o;
  logic [2:0]  mult_trans_id_o;
  logic [0:0]  mult_thread_id_o;

  mult_pipe #(
    .CVA6Cfg   (cva6_cfg_empty),
    .NumStages (N)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .mult_valid_i     (mult_valid_i),
    .mult_ready_o     (mult_ready_o),
    .operation_i      (operation_i),
    .trans_id_i       (trans_id_i),
    .thread_id_i      (thread_id_i),
    .operand_a_i      (operand_a_i),
    .operand_b_i      (operand_b_i),
    .mult_valid_o     (mult_valid_o),
    .mult_ready_i     (mult_ready_i),
    .result_o         (result_o),
    .mult_trans_id_o  (mult_trans_id_o),
    .mult_thread_id_o (mult_thread_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] res;
    logic [2:0]  tid;
    logic        thr;
    int unsigned acc_cyc;
    int unsigned stalls;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] pop_res[$];
  logic [2:0]  pop_tid[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned stall_cnt = 0;
  logic        accepted;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic ref_is_mult(input fu_op op);
    return op inside {MUL, MULH, MULHU, MULHSU, MULW};
  endfunction

  function automatic logic [63:0] ref_mul(input fu_op op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, sb_, ua, ub, p;
    logic [31:0]  w;
    sa  = {{64{a[63]}}, a};
    sb_ = {{64{b[63]}}, b};
    ua  = {64'd0, a};
    ub  = {64'd0, b};
    case (op)
      MUL:    return a * b;
      MULH:   begin p = sa * sb_; return p[127:64]; end
      MULHU:  begin p = ua * ub;  return p[127:64]; end
      MULHSU: begin p = sa * ub;  return p[127:64]; end
      MULW:   begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
      default: return 64'd0;
    endcase
  endfunction

  // One clock cycle: drive, observe at the falling edge, update the model.
  task automatic tick(input logic v, input fu_op op, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] tid, input logic thr, input logic [1:0] fl, input logic rdy);
    exp_t e;
    exp_t keep[$];
    mult_valid_i = v;
    operation_i  = op;
    operand_a_i  = a;
    operand_b_i  = b;
    trans_id_i   = tid;
    thread_id_i  = thr;
    flush_i      = fl;
    mult_ready_i = rdy;
    @(negedge clk_i);
    check("ready", mult_ready_o, rdy || (sb.size() < N));
    if (mult_valid_o && rdy) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("trans_id", mult_trans_id_o, e.tid);
        check("thread_id", mult_thread_id_o, e.thr);
        if (e.stalls == stall_cnt) check("latency", cyc - e.acc_cyc, N);
        pop_res.push_back(result_o);
        pop_tid.push_back(mult_trans_id_o);
      end
    end
    if (fl != 2'b00) begin
      foreach (sb[i]) if (!fl[sb[i].thr]) keep.push_back(sb[i]);
      sb = keep;
    end
    if (!rdy) stall_cnt++;
    accepted = v && mult_ready_o && ref_is_mult(op) && !fl[thr];
    if (accepted) begin
      e.res = ref_mul(op, a, b);
      e.tid = tid;
      e.thr = thr;
      e.acc_cyc = cyc;
      e.stalls = stall_cnt;
      sb.push_back(e);
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, MUL, 64'd0, 64'd0, 3'd0, 1'b0, 2'b00, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1'b1);
    check("drain_empty", sb.size(), 0);
    for (int i = 0; i < N + 1; i++) idle(1'b1);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] r;
    case ($urandom_range(0, 7))
      0: r = 64'd0;
      1: r = 64'd1;
      2: r = '1;
      3: r = 64'h8000_0000_0000_0000;
      4: r = 64'h7FFF_FFFF_FFFF_FFFF;
      5: r = 64'h0000_0000_8000_0000;
      default: r = {$urandom, $urandom};
    endcase
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    flush_i = 2'b00;
    mult_valid_i = 1'b0;
    operation_i = MUL;
    trans_id_i = '0;
    thread_id_i = '0;
    operand_a_i = '0;
    operand_b_i = '0;
    mult_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", mult_valid_o, 0);
    check("rst_ready", mult_ready_o, 1);
    check("rst_result", result_o, 0);
    check("rst_tid", mult_trans_id_o, 0);
    check("rst_thr", mult_thread_id_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Back-to-back throughput and latency
    pop_res.delete();
    tick(1'b1, MUL,  64'd3, 64'd5, 3'd1, 1'b0, 2'b00, 1'b1);
    tick(1'b1, MULH, -64'sd2, 64'd3, 3'd2, 1'b0, 2'b00, 1'b1);
    drain();
    check("tput_count", pop_res.size(), 2);
    if (pop_res.size() == 2) begin
      check("tput_mul", pop_res[0], 64'd15);
      check("tput_mulh", pop_res[1], 64'hFFFF_FFFF_FFFF_FFFF);
    end

    // Individual op results
    pop_res.delete();
    tick(1'b1, MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd3, 1'b1, 2'b00, 1'b1);
    tick(1'b1, MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd4, 1'b0, 2'b00, 1'b1);
    tick(1'b1, MULW,   64'h0000_0000_8000_0000, 64'd1, 3'd5, 1'b1, 2'b00, 1'b1);
    drain();
    check("ops_count", pop_res.size(), 3);
    if (pop_res.size() == 3) begin
      check("mulhu", pop_res[0], 64'd1);
      check("mulhsu", pop_res[1], 64'hFFFF_FFFF_FFFF_FFFF);
      check("mulw", pop_res[2], 64'hFFFF_FFFF_8000_0000);
    end

    // Backpressure: three accepts fill the pipe, the fourth waits
    pop_tid.delete();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, MUL, 64'(i + 1), 64'd7, 3'(i), 1'b0, 2'b00, 1'b0);
      check("bp_accept", accepted, 1);
    end
    tick(1'b1, MUL, 64'd4, 64'd7, 3'd3, 1'b0, 2'b00, 1'b0);
    check("bp_blocked", accepted, 0);
    tick(1'b1, MUL, 64'd4, 64'd7, 3'd3, 1'b0, 2'b00, 1'b1);
    check("bp_release_accept", accepted, 1);
    drain();
    check("bp_count", pop_tid.size(), 4);
    if (pop_tid.size() == 4) for (int i = 0; i < 4; i++) check("bp_order", pop_tid[i], 64'(i));

    // Flush thread 0 while stalled with threads 0,1,0 in flight
    pop_tid.delete();
    tick(1'b1, MUL, 64'd2, 64'd2, 3'd1, 1'b0, 2'b00, 1'b0);
    tick(1'b1, MUL, 64'd3, 64'd3, 3'd2, 1'b1, 2'b00, 1'b0);
    tick(1'b1, MUL, 64'd4, 64'd4, 3'd3, 1'b0, 2'b00, 1'b0);
    mult_valid_i = 1'b0;
    #1;
    check("stalled_valid", mult_valid_o, 1);
    flush_i = 2'b01;
    #1;
    check("flush_gate", mult_valid_o, 0);
    tick(1'b0, MUL, 64'd0, 64'd0, 3'd0, 1'b0, 2'b01, 1'b0);
    drain();
    check("flush_count", pop_tid.size(), 1);
    if (pop_tid.size() == 1) check("flush_survivor", pop_tid[0], 2);

    // Non-mult op is dropped without affecting ready
    tick(1'b1, ADD, 64'd9, 64'd9, 3'd6, 1'b0, 2'b00, 1'b1);
    check("add_dropped", accepted, 0);
    for (int i = 0; i < N + 1; i++) begin
      idle(1'b1);
      check("add_no_result", mult_valid_o, 0);
    end

    // Reset with ops in flight
    tick(1'b1, MUL, 64'd5, 64'd5, 3'd1, 1'b0, 2'b00, 1'b1);
    tick(1'b1, MUL, 64'd6, 64'd6, 3'd2, 1'b1, 2'b00, 1'b1);
    mult_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", mult_valid_o, 0);
    check("midrst_result", result_o, 0);
    sb.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    check("postrst_ready", mult_ready_o, 1);
    check("postrst_valid", mult_valid_o, 0);
    for (int i = 0; i < N + 1; i++) idle(1'b1);

    // Randomized traffic with backpressure and flushes
    for (int i = 0; i < 500; i++) begin
      tick(($urandom_range(0, 3) != 0), fu_op'($urandom_range(0, 7)), rnd64(), rnd64(),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           ($urandom_range(0, 9) < 7));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
